// File: rtl/coeff_rom_arbiter.sv
// Two-port round-robin arbiter in front of a dual-port coefficient ROM, with a per-port
// tag pipeline that re-attaches requester ID and range error to the returning data.
// Build option COEFF_ARB_FIXED_PRIO_EN replaces round-robin with fixed priority (index 0 highest).
module coeff_rom_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32,
   parameter int ROM_LAT   = 3,
   parameter int NUM_WORDS = 8,
   localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [ADDR_W-1:0]          rom_addr_1,
   output logic [ADDR_W-1:0]          rom_addr_2,
   input  logic [DATA_W-1:0]          rom_data_1,
   input  logic [DATA_W-1:0]          rom_data_2,
   output logic                       rsp1_valid,
   output logic [ID_W-1:0]            rsp1_id,
   output logic                       rsp1_err,
   output logic [DATA_W-1:0]          rsp1_data,
   output logic                       rsp2_valid,
   output logic [ID_W-1:0]            rsp2_id,
   output logic                       rsp2_err,
   output logic [DATA_W-1:0]          rsp2_data,
   output logic                       busy
);

   localparam int DEPTH = ROM_LAT + 1;

   logic              p1_vld, p2_vld, p1_err, p2_err;
   logic [ID_W-1:0]   p1_id, p2_id;
   logic [ADDR_W-1:0] p1_addr, p2_addr;
   int                start;

   logic [ADDR_W-1:0] rom_addr_1_q, rom_addr_1_d, rom_addr_2_q, rom_addr_2_d;
   logic [DEPTH-1:0]  tag1_vld_q, tag1_vld_d, tag2_vld_q, tag2_vld_d;
   logic [DEPTH-1:0]  tag1_err_q, tag1_err_d, tag2_err_q, tag2_err_d;
   logic [ID_W-1:0]   tag1_id_q [DEPTH];
   logic [ID_W-1:0]   tag1_id_d [DEPTH];
   logic [ID_W-1:0]   tag2_id_q [DEPTH];
   logic [ID_W-1:0]   tag2_id_d [DEPTH];

`ifndef COEFF_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

   // Stage 0: arbitration. Requesters are visited in order of distance from the scan start.
   always_comb begin
      gnt     = '0;
      p1_vld  = 1'b0;
      p2_vld  = 1'b0;
      p1_id   = '0;
      p2_id   = '0;
      p1_addr = '0;
      p2_addr = '0;
`ifdef COEFF_ARB_FIXED_PRIO_EN
      start   = 0;
`else
      start   = int'(rr_ptr_q);
`endif
      for (int d = 0; d < NUM_REQ; d++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && req[i] && (((i - start + NUM_REQ) % NUM_REQ) == d)) begin
               if (!p1_vld) begin
                  p1_vld  = 1'b1;
                  p1_id   = ID_W'(i);
                  p1_addr = req_addr[i*ADDR_W +: ADDR_W];
                  gnt[i]  = 1'b1;
               end else if (!p2_vld) begin
                  p2_vld  = 1'b1;
                  p2_id   = ID_W'(i);
                  p2_addr = req_addr[i*ADDR_W +: ADDR_W];
                  gnt[i]  = 1'b1;
               end
            end
         end
      end
      p1_err = p1_vld && (int'(p1_addr) >= NUM_WORDS);
      p2_err = p2_vld && (int'(p2_addr) >= NUM_WORDS);
   end

`ifndef COEFF_ARB_FIXED_PRIO_EN
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (p2_vld)
         rr_ptr_d = ID_W'((int'(p2_id) + 1) % NUM_REQ);
      else if (p1_vld)
         rr_ptr_d = ID_W'((int'(p1_id) + 1) % NUM_REQ);
   end

   always_ff @(posedge clk) begin
      if (rst) rr_ptr_q <= '0;
      else     rr_ptr_q <= rr_ptr_d;
   end
`endif

   // Stage 1..DEPTH: address register and tag shift chain, aligned with the ROM data path.
   always_comb begin
      rom_addr_1_d = p1_vld ? p1_addr : rom_addr_1_q;
      rom_addr_2_d = p2_vld ? p2_addr : rom_addr_2_q;
      tag1_vld_d   = {tag1_vld_q[DEPTH-2:0], p1_vld};
      tag2_vld_d   = {tag2_vld_q[DEPTH-2:0], p2_vld};
      tag1_err_d   = {tag1_err_q[DEPTH-2:0], p1_err};
      tag2_err_d   = {tag2_err_q[DEPTH-2:0], p2_err};
      tag1_id_d[0] = p1_id;
      tag2_id_d[0] = p2_id;
      for (int k = 1; k < DEPTH; k++) begin
         tag1_id_d[k] = tag1_id_q[k-1];
         tag2_id_d[k] = tag2_id_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rom_addr_1_q <= '0;
         rom_addr_2_q <= '0;
         tag1_vld_q   <= '0;
         tag2_vld_q   <= '0;
      end else begin
         rom_addr_1_q <= rom_addr_1_d;
         rom_addr_2_q <= rom_addr_2_d;
         tag1_vld_q   <= tag1_vld_d;
         tag2_vld_q   <= tag2_vld_d;
      end
   end

   // Payload fields are qualified by the valid chain, so they carry no reset.
   always_ff @(posedge clk) begin
      tag1_err_q <= tag1_err_d;
      tag2_err_q <= tag2_err_d;
      tag1_id_q  <= tag1_id_d;
      tag2_id_q  <= tag2_id_d;
   end

   assign rom_addr_1 = rom_addr_1_q;
   assign rom_addr_2 = rom_addr_2_q;

   assign rsp1_valid = tag1_vld_q[DEPTH-1];
   assign rsp1_id    = rsp1_valid ? tag1_id_q[DEPTH-1] : '0;
   assign rsp1_err   = rsp1_valid & tag1_err_q[DEPTH-1];
   assign rsp1_data  = rom_data_1;

   assign rsp2_valid = tag2_vld_q[DEPTH-1];
   assign rsp2_id    = rsp2_valid ? tag2_id_q[DEPTH-1] : '0;
   assign rsp2_err   = rsp2_valid & tag2_err_q[DEPTH-1];
   assign rsp2_data  = rom_data_2;

   assign busy = (|req) | (|tag1_vld_q) | (|tag2_vld_q);

endmodule
